// File: rtl/hack_pkg.sv
// hack_pkg: shared types and constants for the Hack ALU and the
// shift-and-add multiplier sequencer.
//   alu_ctrl_t  : packed ALU control word {zx,nx,zy,ny,f,no}
//   ALU_*       : control words used by the sequencer
//   mul_state_t : sequencer FSM states
package hack_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD    = alu_ctrl_t'(6'b000010); // x + y
  localparam alu_ctrl_t ALU_PASS_X = alu_ctrl_t'(6'b001100); // x & 0xFFFF = x
  localparam alu_ctrl_t ALU_ZERO   = alu_ctrl_t'(6'b101010); // constant 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU.
//   x, y   : 16-bit operands
//   zx..no : control bits (zero/negate x, zero/negate y, add-vs-and, negate out)
//   out    : 16-bit result (carry-out discarded)
//   zr, ng : out == 0, out[15]
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x1_s;
  logic [15:0] x2_s;
  logic [15:0] y1_s;
  logic [15:0] y2_s;
  logic [15:0] f_s;

  // Operand preconditioning, function select and output negation.
  always_comb begin
    x1_s = zx ? 16'h0000 : x;
    x2_s = nx ? ~x1_s : x1_s;
    y1_s = zy ? 16'h0000 : y;
    y2_s = ny ? ~y1_s : y1_s;
    f_s  = f ? (x2_s + y2_s) : (x2_s & y2_s);
    out  = no ? ~f_s : f_s;
    zr   = (out == 16'h0000);
    ng   = out[15];
  end

endmodule

// File: rtl/hack_mul_seq.sv
// hack_mul_seq: start/done coprocessor computing the low 16 bits of a*b by
// shift-and-add, routing every add and every doubling through one hack_alu.
//   clk, rst      : clock, synchronous active-high reset
//   start, a, b   : request and operands (sampled only while idle)
//   busy          : high from the cycle after an accepted start through DONE
//   done          : one-cycle pulse; result/zr/ng valid from this cycle
//   result, zr, ng: product, product == 0, product[15]; held until next done
module hack_mul_seq
  import hack_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zr,
  output logic        ng
);

  mul_state_t  state_q,  state_d;
  logic [15:0] acc_q,    acc_d;
  logic [15:0] mcand_q,  mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic [15:0] result_q, result_d;
  logic        zr_q,     zr_d;
  logic        ng_q,     ng_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  logic [15:0] alu_x;
  logic [15:0] alu_y;
  alu_ctrl_t   alu_ctrl;
  logic [15:0] alu_out;

  hack_alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (alu_ctrl.zx),
    .nx  (alu_ctrl.nx),
    .zy  (alu_ctrl.zy),
    .ny  (alu_ctrl.ny),
    .f   (alu_ctrl.f),
    .no  (alu_ctrl.no),
    .out (alu_out),
    .zr  (),
    .ng  ()
  );

  // Next-state, ALU steering and datapath updates.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    alu_x    = acc_q;
    alu_y    = mcand_q;
    alu_ctrl = ALU_PASS_X;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = 16'h0000;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = 4'd0;
          state_d  = ADD;
        end else begin
          state_d  = IDLE;
        end
      end
      ADD: begin
        alu_ctrl = ALU_ADD;
        if (mplier_q[0]) begin
          acc_d = alu_out;
        end else begin
          acc_d = acc_q;
        end
        state_d = DBL;
      end
      DBL: begin
        alu_x    = mcand_q;
        alu_ctrl = ALU_ADD;
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if ((cnt_q == 4'd15) || (EARLY_EXIT && (mplier_d == 16'h0000))) begin
          // acc is final after the last ADD, so capture it on entry to DONE
          // to make result/zr/ng visible in the same cycle as the done pulse.
          result_d = acc_q;
          zr_d     = (acc_q == 16'h0000);
          ng_d     = acc_q[15];
          state_d  = DONE;
        end else begin
          state_d  = ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered views of the state being entered.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 16'h0000;
      cnt_q    <= 4'd0;
      result_q <= 16'h0000;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zr     = zr_q;
  assign ng     = ng_q;

endmodule

// File: tb/tb_hack_mul_seq.sv
// tb_hack_mul_seq: directed self-checking bench for hack_mul_seq, with one
// fixed-latency instance (EARLY_EXIT=0) and one early-exit instance.
module tb_hack_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] a_i = 16'h0000;
  logic [15:0] b_i = 16'h0000;

  logic        busy0, done0, zr0, ng0;
  logic [15:0] result0;
  logic        busy1, done1, zr1, ng1;
  logic [15:0] result1;

  int checks = 0;
  int errors = 0;

  hack_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a_i), .b(b_i),
    .busy(busy0), .done(done0), .result(result0), .zr(zr0), .ng(ng0)
  );

  hack_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a_i), .b(b_i),
    .busy(busy1), .done(done1), .result(result1), .zr(zr1), .ng(ng1)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0, zr0, ng0, result0} !== 20'h0 ||
        {busy1, done1, zr1, ng1, result1} !== 20'h0) begin
      errors++;
      $display("FAIL reset: dut0 b=%b d=%b r=%h zr=%b ng=%b dut1 b=%b d=%b r=%h zr=%b ng=%b, expected all 0",
               busy0, done0, result0, zr0, ng0, busy1, done1, result1, zr1, ng1);
    end
    rst = 1'b0;
  endtask

  // One operation; checks busy/done every cycle and the outputs on done.
  task automatic run_op(input bit sel, input logic [15:0] av, input logic [15:0] bv,
                        input int exp_cyc, input logic [15:0] exp_res,
                        input logic exp_zr, input logic exp_ng, input string name);
    logic bsy, dn, z, n;
    logic [15:0] r;
    @(negedge clk);
    a_i = av;
    b_i = bv;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= exp_cyc + 1; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      bsy = sel ? busy1 : busy0;
      dn  = sel ? done1 : done0;
      r   = sel ? result1 : result0;
      z   = sel ? zr1 : zr0;
      n   = sel ? ng1 : ng0;
      checks++;
      if (bsy !== (c <= exp_cyc) || dn !== (c == exp_cyc)) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b done=%b, expected busy=%b done=%b",
                 name, c, bsy, dn, (c <= exp_cyc), (c == exp_cyc));
      end
      if (c == exp_cyc) begin
        checks++;
        if (r !== exp_res || z !== exp_zr || n !== exp_ng) begin
          errors++;
          $display("FAIL %s result: got %h zr=%b ng=%b, expected %h zr=%b ng=%b",
                   name, r, z, n, exp_res, exp_zr, exp_ng);
        end
      end
    end
  endtask

  task automatic test_fixed_latency();
    run_op(1'b0, 16'd3,    16'd5,    33, 16'h000F, 1'b0, 1'b0, "mul3x5");
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 33, 16'h0001, 1'b0, 1'b0, "neg1xneg1");
    run_op(1'b0, 16'h7FFF, 16'd2,    33, 16'hFFFE, 1'b0, 1'b1, "7fffx2");
    run_op(1'b0, 16'h0100, 16'h0100, 33, 16'h0000, 1'b1, 1'b0, "wrap");
    run_op(1'b0, 16'h1234, 16'h0000, 33, 16'h0000, 1'b1, 1'b0, "by_zero");
    run_op(1'b0, 16'd123,  16'd45,   33, 16'h159F, 1'b0, 1'b0, "123x45");
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    @(negedge clk);
    a_i = 16'd3;
    b_i = 16'd5;
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      if (c == 10) begin
        a_i = 16'd7;
        b_i = 16'd7;
      end
      checks++;
      if (busy0 !== (c != 34) || done0 !== (c == 33 || c == 67)) begin
        errors++;
        $display("FAIL b2b cycle %0d: busy=%b done=%b, expected busy=%b done=%b",
                 c, busy0, done0, (c != 34), (c == 33 || c == 67));
      end
      if (c == 33) begin
        checks++;
        if (result0 !== 16'd15) begin
          errors++;
          $display("FAIL b2b first result: got %0d, expected 15", result0);
        end
      end
      if (c == 67) begin
        checks++;
        if (result0 !== 16'd49) begin
          errors++;
          $display("FAIL b2b second result: got %0d, expected 49", result0);
        end
        start0 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle: busy=%b, expected 0", busy0);
    end
  endtask

  task automatic test_reset_abort();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_i = 16'd3;
    b_i = 16'd5;
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 16'h0000) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b result=%h, expected 0 0 0000",
               busy0, done0, result0);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL abort quiet cycle %0d: busy=%b done=%b, expected 0 0", c, busy0, done0);
      end
    end
    run_op(1'b0, 16'd3, 16'd5, 33, 16'h000F, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_early_exit();
    run_op(1'b1, 16'd3,    16'd5,    7,  16'h000F, 1'b0, 1'b0, "ee_3x5");
    run_op(1'b1, 16'h1234, 16'h0000, 3,  16'h0000, 1'b1, 1'b0, "ee_zero");
    run_op(1'b1, 16'd1,    16'h8000, 33, 16'h8000, 1'b0, 1'b1, "ee_msb");
    run_op(1'b1, 16'd9,    16'd1,    3,  16'h0009, 1'b0, 1'b0, "ee_b1");
  endtask

  initial begin
    test_reset();
    test_fixed_latency();
    test_back_to_back();
    test_reset_abort();
    test_early_exit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_mul_seq.md
Name: hack_mul_seq

Overview:
Multi-cycle multiplier controller that sequences a single hack_alu instance to compute a 16-bit product by shift-and-add. The ALU is the only arithmetic resource: every add and every doubling goes through it. The multiplier shift is a plain register shift. The block sits beside the CPU datapath as a start/done coprocessor and returns the low 16 bits of x*y, which are identical for signed and unsigned operands.

Parameters:
EARLY_EXIT, 0, 1 = finish as soon as the remaining multiplier bits are all zero; 0 = fixed 16-iteration latency

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  16  multiplicand, latched on accepted start
b  input  16  multiplier, latched on accepted start
busy  output  1  high from the cycle after an accepted start through the DONE cycle
done  output  1  one-cycle pulse; result/zr/ng valid from this cycle
result  output  16  low 16 bits of a*b; held until the next done
zr  output  1  result == 0, updated with result
ng  output  1  result[15], updated with result

Behaviour:
- Reset: rst=1 at an edge gives state=IDLE and busy=done=zr=ng=0, result=0, and clears the internal registers (acc, mcand, mplier, cnt[3:0]). Reset mid-operation aborts silently, with no done pulse.
- Internal registers: acc (16), mcand (16), mplier (16), cnt (4).
- ALU control word is {zx,nx,zy,ny,f,no}. ADD = 6'b000010 (x+y). IDLE/DONE drive PASS_X = 6'b001100 with x=acc.
- IDLE, start=1: acc<=0, mcand<=a, mplier<=b, cnt<=0, go to ADD. start while busy is ignored, with no queueing.
- ADD: ALU x=acc, y=mcand, ctrl=ADD. If mplier[0]=1, acc<=alu_out; otherwise acc holds. Go to DBL.
- DBL: ALU x=mcand, y=mcand, ctrl=ADD. mcand<=alu_out, mplier<=mplier>>1, cnt<=cnt+1.
- DBL exit, EARLY_EXIT=0: if cnt==15, go to DONE; otherwise go to ADD.
- DBL exit, EARLY_EXIT=1: if cnt==15 or (mplier>>1)==0, go to DONE; otherwise go to ADD.
- DONE: result<=acc, zr<=(acc==0), ng<=acc[15], done=1 for this cycle only, busy=1. Next state IDLE. A start in the DONE cycle is ignored.
- Latency, EARLY_EXIT=0: start accepted at edge E0; ADD/DBL occupy cycles 1..32; done high in cycle 33; next start is accepted in cycle 34.
- Latency, EARLY_EXIT=1: done in cycle 2k+1, where k = max(1, index of highest set bit of b + 1).
- All arithmetic wraps modulo 2^16. ALU carry-out is discarded. Overflow is not flagged.
- Only the acc and mcand updates take ALU output. zr/ng come from the stored result, not from the live ALU flags.

Decomposition:
- hack_pkg holds:
  - typedef alu_ctrl_t (6-bit packed {zx,nx,zy,ny,f,no});
  - constants ALU_ADD, ALU_PASS_X, ALU_ZERO (6'b101010);
  - enum mul_state_t {IDLE, ADD, DBL, DONE}.
- One sub-module instance: hack_alu, used unmodified; its zr/ng outputs are left unused.
- The FSM and registers live in hack_mul_seq itself.

Test Plan:
- EARLY_EXIT=0, a=3, b=5, start pulse at E0 -> busy=1 in cycles 1..33; done only in cycle 33; result=0x000F, zr=0, ng=0.
- a=0xFFFF, b=0xFFFF -> result=0x0001 (-1*-1); a=0x7FFF, b=2 -> result=0xFFFE, ng=1.
- a=0x0100, b=0x0100 -> result=0x0000, zr=1 (wrap-around); a=0x1234, b=0 -> result=0, zr=1.
- start held high continuously with a=3, b=5, then changing to a=7, b=7 in cycle 10:
  - first done gives 15; operand change mid-op is ignored;
  - next op accepted in cycle 34 yields 49 in cycle 67.
- rst=1 in cycle 12 of an operation -> next cycle busy=0, done never pulses, result keeps reset value 0; a fresh start then completes normally.
- EARLY_EXIT=1:
  - a=3, b=5 -> done in cycle 7, result=15;
  - b=0 -> done in cycle 3, result=0, zr=1;
  - b=0x8000, a=1 -> done in cycle 33, result=0x8000, ng=1.
